// File: rtl/pipe_stage_regs_pkg.sv
// Shared definitions for the IF/ID/EX pipeline register slice:
// control bundle layout, bit positions and NOP constants.
package pipe_stage_regs_pkg;

  localparam int CTRL_W = 9;

  // Bit positions inside {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}
  localparam int CTRL_REGDST   = 8;
  localparam int CTRL_ALUSRC   = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  localparam logic [CTRL_W-1:0] CTRL_NOP  = 9'b0;
  localparam logic [31:0]       INSTR_NOP = 32'b0;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] c);
    return c[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/pipe_stage_regs_pipe_reg.sv
// Generic pipeline register: async active-low reset, synchronous clear
// that wins over load enable.
module pipe_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX pipeline registers with flush, stall and bubble
// handling, plus a saturating count of bubble-inserted cycles.
module pipe_stage_regs
  import pipe_stage_regs_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     pc_next,
  input  logic              pc_write,
  input  logic              if_id_write,
  input  logic              bubble,
  input  logic              flush,
  input  logic [DW-1:0]     if_instr,
  input  logic [DW-1:0]     if_pc4,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DW-1:0]     id_rd1,
  input  logic [DW-1:0]     id_rd2,
  input  logic [DW-1:0]     id_imm,
  output logic [DW-1:0]     pc,
  output logic [DW-1:0]     if_id_instr,
  output logic [DW-1:0]     if_id_pc4,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic [4:0]        id_ex_rs,
  output logic [4:0]        id_ex_rt,
  output logic [4:0]        id_ex_rd,
  output logic [DW-1:0]     id_ex_rd1,
  output logic [DW-1:0]     id_ex_rd2,
  output logic [DW-1:0]     id_ex_imm,
  output logic              id_ex_memread,
  output logic [15:0]       stall_cnt
);

  localparam int IDEX_DATA_W = 3 * 5 + 3 * DW;

  logic                   pc4_en;
  logic [IDEX_DATA_W-1:0] idex_data_d;
  logic [IDEX_DATA_W-1:0] idex_data_q;
  logic [15:0]            stall_cnt_q;
  logic [15:0]            stall_cnt_d;

  pipe_reg #(.WIDTH(DW)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pc_write),
    .clr   (1'b0),
    .d     (pc_next),
    .q     (pc)
  );

  // A flush squashes the instruction to NOP but leaves pc4 untouched.
  pipe_reg #(.WIDTH(DW)) u_if_id_instr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (if_id_write),
    .clr   (flush),
    .d     (if_instr),
    .q     (if_id_instr)
  );

  assign pc4_en = if_id_write & ~flush;

  pipe_reg #(.WIDTH(DW)) u_if_id_pc4 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pc4_en),
    .clr   (1'b0),
    .d     (if_pc4),
    .q     (if_id_pc4)
  );

  // bubble=0 zeroes control so the stalled slot never writes state.
  pipe_reg #(.WIDTH(CTRL_W)) u_id_ex_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .clr   (~bubble),
    .d     (id_ctrl),
    .q     (id_ex_ctrl)
  );

  assign idex_data_d = {id_rs, id_rt, id_rd, id_rd1, id_rd2, id_imm};

  pipe_reg #(.WIDTH(IDEX_DATA_W)) u_id_ex_data (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .clr   (1'b0),
    .d     (idex_data_d),
    .q     (idex_data_q)
  );

  assign {id_ex_rs, id_ex_rt, id_ex_rd, id_ex_rd1, id_ex_rd2, id_ex_imm} = idex_data_q;
  assign id_ex_memread = ctrl_mem_read(id_ex_ctrl);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!bubble && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed plus randomized bench for pipe_stage_regs against a
// behavioural model of the pipeline register rules.
module tb_pipe_stage_regs;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] pc_next;
  logic          pc_write;
  logic          if_id_write;
  logic          bubble;
  logic          flush;
  logic [DW-1:0] if_instr;
  logic [DW-1:0] if_pc4;
  logic [8:0]    id_ctrl;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rd1, id_rd2, id_imm;
  logic [DW-1:0] pc;
  logic [DW-1:0] if_id_instr, if_id_pc4;
  logic [8:0]    id_ex_ctrl;
  logic [4:0]    id_ex_rs, id_ex_rt, id_ex_rd;
  logic [DW-1:0] id_ex_rd1, id_ex_rd2, id_ex_imm;
  logic          id_ex_memread;
  logic [15:0]   stall_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DW-1:0] m_pc, m_instr, m_pc4, m_rd1, m_rd2, m_imm;
  logic [8:0]    m_ctrl;
  logic [4:0]    m_rs, m_rt, m_rd;
  int            m_stall;

  pipe_stage_regs #(.DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_next       (pc_next),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .bubble        (bubble),
    .flush         (flush),
    .if_instr      (if_instr),
    .if_pc4        (if_pc4),
    .id_ctrl       (id_ctrl),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_rd1        (id_rd1),
    .id_rd2        (id_rd2),
    .id_imm        (id_imm),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .id_ex_ctrl    (id_ex_ctrl),
    .id_ex_rs      (id_ex_rs),
    .id_ex_rt      (id_ex_rt),
    .id_ex_rd      (id_ex_rd),
    .id_ex_rd1     (id_ex_rd1),
    .id_ex_rd2     (id_ex_rd2),
    .id_ex_imm     (id_ex_imm),
    .id_ex_memread (id_ex_memread),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    chk({step, ":pc"}, pc, m_pc);
    chk({step, ":if_id_instr"}, if_id_instr, m_instr);
    chk({step, ":if_id_pc4"}, if_id_pc4, m_pc4);
    chk({step, ":id_ex_ctrl"}, 32'(id_ex_ctrl), 32'(m_ctrl));
    chk({step, ":id_ex_regs"}, 32'({id_ex_rs, id_ex_rt, id_ex_rd}), 32'({m_rs, m_rt, m_rd}));
    chk({step, ":id_ex_rd1"}, id_ex_rd1, m_rd1);
    chk({step, ":id_ex_rd2"}, id_ex_rd2, m_rd2);
    chk({step, ":id_ex_imm"}, id_ex_imm, m_imm);
    chk({step, ":memread"}, 32'(id_ex_memread), 32'(m_ctrl[4]));
    chk({step, ":stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
  endtask

  task automatic model_reset();
    m_pc = '0; m_instr = '0; m_pc4 = '0; m_ctrl = '0;
    m_rs = '0; m_rt = '0; m_rd = '0;
    m_rd1 = '0; m_rd2 = '0; m_imm = '0;
    m_stall = 0;
  endtask

  task automatic rand_data();
    pc_next  = $urandom;
    if_instr = $urandom;
    if_pc4   = $urandom;
    id_ctrl  = 9'($urandom);
    id_rs    = 5'($urandom);
    id_rt    = 5'($urandom);
    id_rd    = 5'($urandom);
    id_rd1   = $urandom;
    id_rd2   = $urandom;
    id_imm   = $urandom;
  endtask

  task automatic set_ctl(input logic pw, input logic iw, input logic bb, input logic fl);
    pc_write = pw; if_id_write = iw; bubble = bb; flush = fl;
  endtask

  // One rising edge: the model applies the rules to the inputs held over
  // that edge, then new inputs may be driven after the falling edge.
  task automatic tick();
    @(posedge clk);
    if (pc_write) m_pc = pc_next;
    if (flush) m_instr = 32'h0;
    else if (if_id_write) begin
      m_instr = if_instr;
      m_pc4   = if_pc4;
    end
    m_ctrl = bubble ? id_ctrl : 9'h000;
    m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
    m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
    if (!bubble) m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] hold_pc, hold_instr;
    rst_n = 1'b1;
    rand_data();
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0);
    model_reset();

    // Reset asserted mid-cycle with nonzero inputs clears everything at once
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    check_all("reset_held");

    // Normal flow: pc follows pc_next with one cycle of lag
    for (int i = 1; i <= 3; i++) begin
      rand_data();
      set_ctl(1'b1, 1'b1, 1'b1, 1'b0);
      pc_next = 32'(i * 4);
      tick();
      chk("flow_pc_direct", pc, 32'(i * 4));
      chk("flow_instr_direct", if_id_instr, if_instr);
      check_all("flow");
    end

    // Load-use stall
    hold_pc    = pc;
    hold_instr = if_id_instr;
    rand_data();
    id_ctrl = 9'h1FF;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("stall_pc_held", pc, hold_pc);
    chk("stall_instr_held", if_id_instr, hold_instr);
    chk("stall_ctrl_nop", 32'(id_ex_ctrl), 32'h0);
    chk("stall_cnt_one", 32'(stall_cnt), 32'd1);
    check_all("stall");

    // Flush overrides if_id_write=0
    rand_data();
    if_instr = 32'h8C220004;
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("flush_instr_nop", if_id_instr, 32'h0);
    check_all("flush");

    // id_ex_memread follows the MemRead bit only when bubble=1
    rand_data();
    id_ctrl = 9'h010;
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("memread_pass", 32'(id_ex_memread), 32'd1);
    check_all("memread_pass");
    rand_data();
    id_ctrl = 9'h010;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("memread_bubble", 32'(id_ex_memread), 32'd0);
    check_all("memread_bubble");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      rand_data();
      set_ctl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0));
      tick();
      check_all("random");
    end

    // Reset during a stall discards it; first edge afterwards loads normally
    rand_data();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("reset_mid_stall");
    @(negedge clk);
    rst_n = 1'b1;
    rand_data();
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check_all("after_reset");

    // Saturation of the stall counter
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) begin
      tick();
    end
    chk("sat_value", 32'(stall_cnt), 32'h0000FFFF);
    check_all("sat");
    rand_data();
    tick();
    chk("sat_stays", 32'(stall_cnt), 32'h0000FFFF);
    check_all("sat_stays");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_regs.md
PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs

Interface
REQ-001 Parameter: DW, default 32, datapath/PC width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 pc_next  input  DW  next PC from PC-select mux.
REQ-005 pc_write  input  1  1 = PC loads pc_next; 0 = PC holds.
REQ-006 if_id_write  input  1  1 = IF/ID loads; 0 = IF/ID holds.
REQ-007 bubble  input  1  1 = pass ID control into ID/EX; 0 = insert NOP control.
REQ-008 flush  input  1  taken branch/jump resolved in ID; squashes IF/ID.
REQ-009 if_instr, if_pc4  input  DW each  fetched instruction, PC+4.
REQ-010 id_ctrl  input  9  {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}.
REQ-011 id_rs, id_rt, id_rd  input  5 each  decoded register fields.
REQ-012 id_rd1, id_rd2, id_imm  input  DW each  register-file data, sign-extended immediate.
REQ-013 pc  output  DW  current PC.
REQ-014 if_id_instr, if_id_pc4  output  DW each  IF/ID contents.
REQ-015 id_ex_ctrl, id_ex_rs, id_ex_rt, id_ex_rd, id_ex_rd1, id_ex_rd2, id_ex_imm  output  ID/EX contents, widths as inputs.
REQ-016 id_ex_memread  output  1  alias of id_ex_ctrl MemRead bit, fed back to hazard detection.
REQ-017 stall_cnt  output  16  count of bubble-inserted cycles.

Function
REQ-018 PC SHALL load pc_next on clk edge when pc_write=1, else hold; one-cycle latency.
REQ-019 IF/ID SHALL follow priority: flush=1 -> instr=0 (NOP), pc4 held; else if_id_write=1 -> load if_instr/if_pc4; else hold.
REQ-020 flush SHALL override if_id_write=0 in the same cycle.
REQ-021 ID/EX data fields (rs, rt, rd, rd1, rd2, imm) SHALL load every cycle unconditionally.
REQ-022 id_ex_ctrl SHALL load id_ctrl when bubble=1 and 9'b0 when bubble=0, so a bubble never writes registers or memory.
REQ-023 stall_cnt SHALL increment by 1 on each edge where bubble=0, saturating at 16'hFFFF (no wrap).
REQ-024 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-025 A load-use stall SHALL be realised as: pc_write=0, if_id_write=0, bubble=0 for one cycle -> PC and IF/ID hold, ID/EX holds NOP control, instruction re-decoded next cycle.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, clear pc, all IF/ID and ID/EX fields, id_ex_memread and stall_cnt to 0.
REQ-027 Reset asserted mid-stall SHALL discard the stall; after release first edge loads normally per inputs.
REQ-028 Deassertion SHALL take effect on the first rising clk edge with rst_n=1.

Structure
REQ-029 Shared package SHALL hold control bundle width (9), bit indices of each control signal, NOP control constant 9'b0, NOP instruction constant 32'b0.
REQ-030 One sub-module pipe_reg (parameter width; ports clk, rst_n, en, clr, d, q; clr priority over en) SHALL implement PC, IF/ID and ID/EX registers.
REQ-031 stall_cnt SHALL be implemented in the top module, not in pipe_reg.

Verification
REQ-032 Reset: drive inputs nonzero, rst_n=0 mid-cycle -> all outputs 0 before next edge; stall_cnt=0.
REQ-033 Normal flow: pc_next=0x4,0x8,0xC with all enables 1 -> pc follows with 1-cycle lag; if_id_instr tracks if_instr.
REQ-034 Load-use stall: one cycle pc_write=if_id_write=bubble=0 with id_ctrl=9'h1FF -> pc and if_id_instr unchanged, id_ex_ctrl=0, stall_cnt=1.
REQ-035 Flush vs stall: flush=1 and if_id_write=0 same cycle, if_instr=0x8C220004 -> if_id_instr=0.
REQ-036 Saturation: force 65540 bubble cycles -> stall_cnt=16'hFFFF, stays.
REQ-037 id_ex_memread: id_ctrl MemRead=1, bubble=1 -> id_ex_memread=1 next edge; same with bubble=0 -> 0.
